// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP controller-sequencer: opcodes, T-state encoding
// and control-word bit positions.
package sap_ctrl_pkg;

  localparam int OPCODE_W = 4;
  localparam int NUM_T    = 6;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

  // One-hot positions; bits [TS_T6:TS_BOOT] double as the debug tstate bus.
  localparam int TS_BOOT = 0;
  localparam int TS_T1   = 1;
  localparam int TS_T6   = 6;
  localparam int TS_HALT = 7;
  localparam int TS_W    = 8;

  typedef enum logic [TS_W-1:0] {
    ST_BOOT = 8'b0000_0001,
    ST_T1   = 8'b0000_0010,
    ST_T2   = 8'b0000_0100,
    ST_T3   = 8'b0000_1000,
    ST_T4   = 8'b0001_0000,
    ST_T5   = 8'b0010_0000,
    ST_T6   = 8'b0100_0000,
    ST_HALT = 8'b1000_0000
  } state_t;

  localparam int CW_CP = 0;
  localparam int CW_LP = 1;
  localparam int CW_LM = 2;
  localparam int CW_CE = 3;
  localparam int CW_WE = 4;
  localparam int CW_LI = 5;
  localparam int CW_EI = 6;
  localparam int CW_LA = 7;
  localparam int CW_EA = 8;
  localparam int CW_LB = 9;
  localparam int CW_EU = 10;
  localparam int CW_SU = 11;
  localparam int CW_LO = 12;
  localparam int CW_W  = 13;

  function automatic logic [CW_W-1:0] cwBit(input int idx);
    return CW_W'(1) << idx;
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring: BOOT, T1..T6, with run-hold and a terminal HALT state
// that only reset can leave.
module sap_ring_counter
  import sap_ctrl_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_run,
  input  logic   i_halt_req,
  output state_t o_state
);

  state_t r_state;

  // BOOT always advances; T4 diverts to HALT when the decoded opcode is HLT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_BOOT;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_T1;
        ST_T1:   if (i_run) r_state <= ST_T2;
        ST_T2:   if (i_run) r_state <= ST_T3;
        ST_T3:   if (i_run) r_state <= ST_T4;
        ST_T4:   if (i_run) r_state <= i_halt_req ? ST_HALT : ST_T5;
        ST_T5:   if (i_run) r_state <= ST_T6;
        ST_T6:   if (i_run) r_state <= ST_T1;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP controller-sequencer: decodes ring state, opcode and flags into the PC
// controls and the register-file control word.
module sap_controller_sequencer
  import sap_ctrl_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_carry,
  input  logic                i_zero,
  output logic                o_pc_clr_n,
  output logic                o_pc_cp,
  output logic                o_pc_ep,
  output logic                o_pc_lp,
  output logic                o_lm,
  output logic                o_ce,
  output logic                o_we,
  output logic                o_li,
  output logic                o_ei,
  output logic                o_la,
  output logic                o_ea,
  output logic                o_lb,
  output logic                o_eu,
  output logic                o_su,
  output logic                o_lo,
  output logic                o_halted,
  output logic [NUM_T:0]      o_tstate
);

  state_t          w_state;
  logic [CW_W-1:0] w_cw;
  logic [CW_W-1:0] w_cw_gated;
  logic            w_active;

  sap_ring_counter u_ring (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (i_run),
    .i_halt_req (i_opcode == OP_HLT),
    .o_state    (w_state)
  );

  // Raw micro-ops per state; run/reset gating is applied afterwards.
  always_comb begin
    w_cw = '0;
    case (w_state)
      ST_T1: w_cw = cwBit(CW_LM);
      ST_T2: w_cw = cwBit(CW_CP);
      ST_T3: w_cw = cwBit(CW_CE) | cwBit(CW_LI);
      ST_T4: begin
        case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w_cw = cwBit(CW_EI) | cwBit(CW_LM);
          OP_JMP: w_cw = cwBit(CW_EI) | cwBit(CW_LP);
          OP_JC:  w_cw = cwBit(CW_EI) | (i_carry ? cwBit(CW_LP) : '0);
          OP_JZ:  w_cw = cwBit(CW_EI) | (i_zero ? cwBit(CW_LP) : '0);
          OP_OUT: w_cw = cwBit(CW_EA) | cwBit(CW_LO);
          default: w_cw = '0;
        endcase
      end
      ST_T5: begin
        case (i_opcode)
          OP_LDA:         w_cw = cwBit(CW_CE) | cwBit(CW_LA);
          OP_ADD, OP_SUB: w_cw = cwBit(CW_CE) | cwBit(CW_LB);
          OP_STA:         w_cw = cwBit(CW_EA) | cwBit(CW_WE);
          default:        w_cw = '0;
        endcase
      end
      ST_T6: begin
        case (i_opcode)
          OP_ADD:  w_cw = cwBit(CW_EU) | cwBit(CW_LA);
          OP_SUB:  w_cw = cwBit(CW_EU) | cwBit(CW_SU) | cwBit(CW_LA);
          default: w_cw = '0;
        endcase
      end
      default: w_cw = '0;
    endcase
  end

  assign w_active   = ~i_rst & i_run;
  assign w_cw_gated = w_cw & {CW_W{w_active}};

  assign o_pc_cp = w_cw_gated[CW_CP];
  assign o_pc_lp = w_cw_gated[CW_LP];
  assign o_lm    = w_cw_gated[CW_LM];
  assign o_ce    = w_cw_gated[CW_CE];
  assign o_we    = w_cw_gated[CW_WE];
  assign o_li    = w_cw_gated[CW_LI];
  assign o_ei    = w_cw_gated[CW_EI];
  assign o_la    = w_cw_gated[CW_LA];
  assign o_ea    = w_cw_gated[CW_EA];
  assign o_lb    = w_cw_gated[CW_LB];
  assign o_eu    = w_cw_gated[CW_EU];
  assign o_su    = w_cw_gated[CW_SU];
  assign o_lo    = w_cw_gated[CW_LO];

  // The PC registers ep, so it is raised one state ahead of the T1 bus slot.
  assign o_pc_ep = ~i_rst & ((w_state == ST_BOOT) | (w_state == ST_T6) |
                             ((w_state == ST_T1) & ~i_run));

  assign o_pc_clr_n = ~i_rst;
  assign o_halted   = ~i_rst & (w_state == ST_HALT);
  assign o_tstate   = i_rst ? 7'b000_0001 : w_state[TS_T6:TS_BOOT];

endmodule
